// File: rtl/m6809_pkg.sv
// Shared definitions for the core6809 timer target: register offsets,
// CTRL/STATUS bit positions and the run-state encoding.
package m6809_pkg;

  localparam logic [2:0] TMR_CTRL      = 3'd0;
  localparam logic [2:0] TMR_STATUS    = 3'd1;
  localparam logic [2:0] TMR_RELOAD_HI = 3'd2;
  localparam logic [2:0] TMR_RELOAD_LO = 3'd3;
  localparam logic [2:0] TMR_COUNT_HI  = 3'd4;
  localparam logic [2:0] TMR_COUNT_LO  = 3'd5;
  localparam logic [2:0] TMR_PRESCALE  = 3'd6;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_AUTO   = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  localparam int unsigned STAT_EXPIRED = 0;
  localparam int unsigned STAT_RUNNING = 1;

  typedef enum logic {
    TMR_IDLE = 1'b0,
    TMR_RUN  = 1'b1
  } tmr_state_e;

endpackage

// File: rtl/m6809_prescaler.sv
// Free-running 0..divisor counter; tick is high in the cycle the count
// equals the divisor. A count above a newly lowered divisor wraps at 8'hFF.
module m6809_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       clear,
  input  logic [7:0] divisor,
  output logic       tick
);

  logic [7:0] cnt_q;

  assign tick = enable && (cnt_q == divisor);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tick ? 8'd0 : cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/m6809_timer_target.sv
// Memory-mapped 16-bit down-counter timer for the core6809 bus with
// prescaler, sticky expiry flag, atomic 16-bit access and active-low IRQ.
module m6809_timer_target
  import m6809_pkg::*;
#(
  parameter logic [15:0] RELOAD_RST   = 16'hFFFF,
  parameter logic [7:0]  PRESCALE_RST = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel,
  input  logic [2:0] addr,
  input  logic [7:0] data_in,
  input  logic       data_rw_n,
  output logic [7:0] data_out,
  output logic       irq_b
);

  tmr_state_e state_q, state_d;
  logic        auto_q, irq_en_q, expired_q;
  logic [15:0] reload_q, count_q;
  logic [7:0]  prescale_q, hold_q, latch_q;
  logic        en, wr_en, rd_en, ctrl_wr, pre_clear, tick, tick_eff, expire;

  assign en        = (state_q == TMR_RUN);
  assign wr_en     = sel && !data_rw_n;
  assign rd_en     = sel && data_rw_n;
  assign ctrl_wr   = wr_en && (addr == TMR_CTRL);
  assign pre_clear = ctrl_wr && data_in[CTRL_EN] && !en;
  // A CTRL write owns the cycle: any coincident tick is dropped.
  assign tick_eff  = tick && !ctrl_wr;
  assign expire    = tick_eff && (count_q == 16'd0);

  m6809_prescaler u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .enable  (en),
    .clear   (pre_clear),
    .divisor (prescale_q),
    .tick    (tick)
  );

  always_comb begin
    state_d = state_q;
    if (ctrl_wr) begin
      state_d = data_in[CTRL_EN] ? TMR_RUN : TMR_IDLE;
    end else if (expire && !auto_q) begin
      state_d = TMR_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= TMR_IDLE;
      auto_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      expired_q  <= 1'b0;
      reload_q   <= RELOAD_RST;
      count_q    <= RELOAD_RST;
      prescale_q <= PRESCALE_RST;
      hold_q     <= '0;
      latch_q    <= '0;
    end else begin
      state_q <= state_d;
      if (wr_en) begin
        case (addr)
          TMR_CTRL: begin
            auto_q   <= data_in[CTRL_AUTO];
            irq_en_q <= data_in[CTRL_IRQ_EN];
          end
          TMR_STATUS: if (data_in[STAT_EXPIRED]) expired_q <= 1'b0;
          TMR_RELOAD_HI: hold_q <= data_in;
          TMR_RELOAD_LO: begin
            reload_q <= {hold_q, data_in};
            if (!en) count_q <= {hold_q, data_in};
          end
          TMR_PRESCALE: prescale_q <= data_in;
          default: ;
        endcase
      end
      if (rd_en && (addr == TMR_COUNT_HI)) latch_q <= count_q[7:0];
      // Expiry is placed after the STATUS clear so a same-cycle set wins.
      if (tick_eff) begin
        if (count_q != 16'd0) begin
          count_q <= count_q - 16'd1;
        end else begin
          expired_q <= 1'b1;
          if (auto_q) count_q <= reload_q;
        end
      end
    end
  end

  always_comb begin
    data_out = '0;
    if (sel) begin
      case (addr)
        TMR_CTRL:      data_out = {5'b0, irq_en_q, auto_q, en};
        TMR_STATUS:    data_out = {6'b0, en, expired_q};
        TMR_RELOAD_HI: data_out = reload_q[15:8];
        TMR_RELOAD_LO: data_out = reload_q[7:0];
        TMR_COUNT_HI:  data_out = count_q[15:8];
        TMR_COUNT_LO:  data_out = latch_q;
        TMR_PRESCALE:  data_out = prescale_q;
        default:       data_out = '0;
      endcase
    end
  end

  assign irq_b = !(expired_q && irq_en_q);

endmodule

// File: doc/m6809_timer_target.md
Name: m6809_timer_target

Overview:
- Memory-mapped bus target (responder) for the core6809 data bus: a 16-bit programmable down-counter timer with prescaler, sticky expiry flag and active-low IRQ.
- The integration layer decodes its address window to `sel` and drives the core's address, write data and `data_rw_n` in.
- Read data is returned to the core's `data_in` mux. Registers are 8-bit, big-endian for 16-bit values, with 6809-style atomic high/low byte access.

Parameters:
- RELOAD_RST, 16'hFFFF: reset value of RELOAD and COUNT.
- PRESCALE_RST, 8'h00: reset value of PRESCALE. A tick occurs every PRESCALE+1 clocks.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- sel  in  1  window select from address decode. Qualifies every access.
- addr  in  3  register offset (core addr[2:0]).
- data_in  in  8  write data from core data_out.
- data_rw_n  in  1  1 = read, 0 = write.
- data_out  out  8  read data to core data_in. Combinational. Reads 0 when sel=0.
- irq_b  out  1  active-low interrupt = ~(EXPIRED & IRQ_EN).

Behaviour:
- Reset values:
  - CTRL=0, EXPIRED=0, RELOAD=COUNT=RELOAD_RST, PRESCALE=PRESCALE_RST.
  - prescaler counter=0, hold and latch bytes=0.
  - irq_b=1, data_out=0.
- Access timing:
  - A write takes effect at the clock edge where sel=1 and data_rw_n=0.
  - Read data is valid in the same cycle (zero latency). Read side effects occur at that cycle's edge.
- Register map (offset):
  - 0 CTRL, RW: bit0 EN, bit1 AUTO, bit2 IRQ_EN; bits 7:3 read 0.
  - 1 STATUS: bit0 EXPIRED (write 1 to clear), bit1 RUNNING (=EN, read-only).
  - 2 RELOAD_HI: a write stores the hold byte only. A read returns RELOAD[15:8].
  - 3 RELOAD_LO: a write commits RELOAD={hold, data_in}. If EN=0, it also loads COUNT with the same value. A read returns RELOAD[7:0].
  - 4 COUNT_HI, RO: returns COUNT[15:8] and snapshots COUNT[7:0] into the latch.
  - 5 COUNT_LO, RO: returns the latch.
  - 6 PRESCALE, RW.
  - 7: reads 0; writes ignored.
  - Writes to 4/5 are ignored.
- Prescaler:
  - Runs only while EN=1.
  - Counts 0..PRESCALE. The cycle it equals PRESCALE is a tick, and it then wraps to 0.
  - A write to CTRL that sets EN from 0 to 1 clears the prescaler, so the first tick occurs PRESCALE+1 clocks later.
- Tick behaviour:
  - COUNT!=0: COUNT decrements by 1.
  - COUNT==0: EXPIRED is set.
    - AUTO=1: COUNT reloads from RELOAD.
    - AUTO=0: EN clears (one-shot) and COUNT stays 0.
- State summary: IDLE (EN=0), RUNNING (EN=1, COUNT>0), EXPIRE (tick at COUNT==0) → RUNNING if AUTO, else IDLE.
- Simultaneous events:
  - CTRL write and tick in the same cycle: the write wins and the tick is discarded.
  - STATUS clear and expiry in the same cycle: EXPIRED stays 1 (set wins).
  - RELOAD_LO commit and expiry reload with EN=1: the count reloads the old RELOAD value, and the new value applies from the next expiry.
  - PRESCALE write while running: takes effect immediately. If the prescaler counter is greater than the new value, it wraps at 8'hFF.
- Arithmetic: all unsigned with no saturation. COUNT never wraps below 0, because a tick at 0 is the expire path.
- Reset mid-operation: all state returns to reset values on the next edge, and irq_b deasserts that cycle.

Decomposition:
- Shared package m6809_pkg holds:
  - register offset constants (TMR_CTRL..TMR_PRESCALE)
  - CTRL bit indices (EN, AUTO, IRQ_EN)
  - STATUS bit indices
- One natural sub-module: m6809_prescaler. It takes an enable, a clear and an 8-bit divisor, and outputs a tick pulse.

Test Plan:
- Reset, then read offsets 0..7: expect 00,00,FF,FF,FF,FF,00,00, with irq_b=1.
- Write RELOAD 0x0003 (2←00, 3←03) with EN=0, then read COUNT_HI/LO: expect 00/03.
- Write CTRL=0x05 with PRESCALE=0. Expect:
  - COUNT values 2,1,0 over the next 3 clocks;
  - EXPIRED=1 and irq_b=0 on the 4th tick;
  - EN=0 and STATUS=0x01.
  - Then write STATUS=0x01: expect irq_b=1.
- With PRESCALE=3, AUTO=1, RELOAD=0x0001, EN=1: expect EXPIRED to set every 8 clocks (2 ticks × 4 clocks), and COUNT to cycle 1,0,1.
- Latch atomicity with COUNT=0x0100 decrementing:
  - read COUNT_HI at count 0x0100: returns 01;
  - read COUNT_LO after the count reaches 0x00FF: returns latched 00, not FF.
- Same-cycle STATUS write-1-clear and expiry tick: expect EXPIRED=1. Same-cycle CTRL write (EN=0) and tick: expect COUNT unchanged.
